fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline; owns the PC, issues instruction-bus requests, and fills the IF/ID register (instruction, pc, pc_plus_4) consumed by decode.
- Obeys the fetch stall/flush pair from the hazard unit.
- Accepts PC redirects from branch/jump resolution (J, BEQ).
- No branch delay slot.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, instruction-bus requests, IF/ID register
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   ireq_valid, ireq_addr       instruction request (held stable until iresp_data_ok)
//   iresp_data_ok, iresp_data   request completion and fetched word (same cycle allowed)
//   stall, flush                hazard-unit controls for the IF/ID register
//   redirect_valid, redirect_pc taken branch/jump target
//   fd_valid, fd_instruction,
//   fd_pc, fd_pc_plus_4         IF/ID register contents for decode
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [31:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fd_valid,
   output logic [31:0] fd_instruction,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_pc_plus_4
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DRAIN = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] hold_data_q, hold_data_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        fd_valid_q, fd_valid_d;
   logic [31:0] fd_instruction_q, fd_instruction_d;
   logic [31:0] fd_pc_q, fd_pc_d;
   logic [31:0] fd_pc_plus_4_q, fd_pc_plus_4_d;

   // A fetch that is ready to enter IF/ID this cycle (from the bus or the hold buffer)
   logic        load_ok;
   logic [31:0] load_instr;
   logic [31:0] load_pc;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      target_d    = target_q;
      hold_data_d = hold_data_q;
      hold_pc_d   = hold_pc_q;
      load_ok     = 1'b0;
      load_instr  = iresp_data;
      load_pc     = pc_q;

      case (state_q)
         S_FETCH: begin
            if (iresp_data_ok) begin
               if (redirect_valid) begin
                  pc_d = redirect_pc & ALIGN_MASK;
               end else if (!stall) begin
                  load_ok = 1'b1;
                  pc_d    = pc_q + 32'd4;
               end else begin
                  // Decode can't take it yet; park the word and stop requesting
                  hold_data_d = iresp_data;
                  hold_pc_d   = pc_q;
                  state_d     = S_HOLD;
               end
            end else if (redirect_valid) begin
               // The request can't be withdrawn, so remember where to go once it completes
               target_d = redirect_pc;
               state_d  = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (redirect_valid) begin
               target_d = redirect_pc;
            end
            if (iresp_data_ok) begin
               pc_d    = (redirect_valid ? redirect_pc : target_q) & ALIGN_MASK;
               state_d = S_FETCH;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc & ALIGN_MASK;
               state_d = S_FETCH;
            end else if (!stall) begin
               load_ok    = 1'b1;
               load_instr = hold_data_q;
               load_pc    = hold_pc_q;
               pc_d       = hold_pc_q + 32'd4;
               state_d    = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      fd_valid_d       = fd_valid_q;
      fd_instruction_d = fd_instruction_q;
      fd_pc_d          = fd_pc_q;
      fd_pc_plus_4_d   = fd_pc_plus_4_q;
      if (flush) begin
         fd_valid_d = 1'b0;
      end else if (stall) begin
         fd_valid_d = fd_valid_q;
      end else if (load_ok) begin
         fd_valid_d       = 1'b1;
         fd_instruction_d = load_instr;
         fd_pc_d          = load_pc;
         fd_pc_plus_4_d   = load_pc + 32'd4;
      end else begin
         fd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= S_FETCH;
         pc_q             <= RESET_PC & ALIGN_MASK;
         target_q         <= 32'd0;
         hold_data_q      <= 32'd0;
         hold_pc_q        <= 32'd0;
         fd_valid_q       <= 1'b0;
         fd_instruction_q <= 32'd0;
         fd_pc_q          <= 32'd0;
         fd_pc_plus_4_q   <= 32'd0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         target_q         <= target_d;
         hold_data_q      <= hold_data_d;
         hold_pc_q        <= hold_pc_d;
         fd_valid_q       <= fd_valid_d;
         fd_instruction_q <= fd_instruction_d;
         fd_pc_q          <= fd_pc_d;
         fd_pc_plus_4_q   <= fd_pc_plus_4_d;
      end
   end

   // The request is only dropped while a word sits in the hold buffer
   assign ireq_valid     = (state_q != S_HOLD);
   assign ireq_addr      = pc_q;
   assign fd_valid       = fd_valid_q;
   assign fd_instruction = fd_instruction_q;
   assign fd_pc          = fd_pc_q;
   assign fd_pc_plus_4   = fd_pc_plus_4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fd_valid;
   logic [31:0] fd_instruction;
   logic [31:0] fd_pc;
   logic [31:0] fd_pc_plus_4;

   logic        ok_en;
   int          total;
   int          bad;

   fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fd_valid       (fd_valid),
      .fd_instruction (fd_instruction),
      .fd_pc          (fd_pc),
      .fd_pc_plus_4   (fd_pc_plus_4)
   );

   // Memory model: word = address inverted; ok_en selects whether it answers this cycle
   assign iresp_data    = ireq_addr ^ 32'hFFFF_FFFF;
   assign iresp_data_ok = ok_en & ireq_valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      ok_en = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      step();
      step();

      // Reset state
      chk("rst_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("rst_fd_pc", fd_pc, 32'd0);
      chk("rst_fd_instr", fd_instruction, 32'd0);
      chk("rst_ireq_addr", ireq_addr, 32'hBFC0_0000);
      reset = 1'b0;
      chk("rst_ireq_valid", {31'd0, ireq_valid}, 32'd1);

      // 0-wait streaming
      ok_en = 1'b1;
      step();
      chk("s0_ireq_addr", ireq_addr, 32'hBFC0_0004);
      chk("s0_fd_valid", {31'd0, fd_valid}, 32'd1);
      chk("s0_fd_pc", fd_pc, 32'hBFC0_0000);
      chk("s0_fd_pc4", fd_pc_plus_4, 32'hBFC0_0004);
      chk("s0_fd_instr", fd_instruction, 32'h403F_FFFF);
      step();
      chk("s1_ireq_addr", ireq_addr, 32'hBFC0_0008);
      chk("s1_fd_pc", fd_pc, 32'hBFC0_0004);
      chk("s1_fd_pc4", fd_pc_plus_4, 32'hBFC0_0008);

      // Fresh reset, then redirect during the first wait of a 2-wait fetch
      ok_en = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1000;
      step();
      redirect_valid = 1'b0;
      chk("dr_ireq_addr0", ireq_addr, 32'hBFC0_0000);
      chk("dr_ireq_valid0", {31'd0, ireq_valid}, 32'd1);
      step();
      chk("dr_ireq_addr1", ireq_addr, 32'hBFC0_0000);
      ok_en = 1'b1;
      step();
      chk("dr_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("dr_next_addr", ireq_addr, 32'h0000_1000);

      // Two redirects while draining: the latest target wins
      ok_en = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_3000;
      step();
      redirect_pc = 32'h0000_2000;
      step();
      redirect_valid = 1'b0;
      chk("dr2_ireq_addr", ireq_addr, 32'h0000_1000);
      ok_en = 1'b1;
      step();
      chk("dr2_next_addr", ireq_addr, 32'h0000_2000);
      chk("dr2_fd_valid", {31'd0, fd_valid}, 32'd0);

      // Stall for 3 cycles while the word for 0x2004 returns
      step();
      chk("st_fd_pc_pre", fd_pc, 32'h0000_2000);
      chk("st_addr_pre", ireq_addr, 32'h0000_2004);
      stall = 1'b1;
      step();
      chk("st_ireq_valid0", {31'd0, ireq_valid}, 32'd0);
      chk("st_fd_pc0", fd_pc, 32'h0000_2000);
      chk("st_fd_valid0", {31'd0, fd_valid}, 32'd1);
      step();
      step();
      chk("st_ireq_valid2", {31'd0, ireq_valid}, 32'd0);
      chk("st_fd_pc2", fd_pc, 32'h0000_2000);
      stall = 1'b0;
      step();
      chk("st_rel_fd_pc", fd_pc, 32'h0000_2004);
      chk("st_rel_fd_instr", fd_instruction, 32'hFFFF_DFFB);
      chk("st_rel_fd_valid", {31'd0, fd_valid}, 32'd1);
      chk("st_rel_addr", ireq_addr, 32'h0000_2008);
      step();
      chk("st_after_fd_pc", fd_pc, 32'h0000_2008);

      // Flush together with stall, plus an unaligned redirect
      flush = 1'b1;
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1003;
      step();
      flush = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      chk("fl_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("fl_ireq_addr", ireq_addr, 32'h0000_1000);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      step();
      redirect_valid = 1'b0;
      chk("wr_ireq_addr", ireq_addr, 32'hFFFF_FFFC);
      step();
      chk("wr_fd_pc", fd_pc, 32'hFFFF_FFFC);
      chk("wr_fd_pc4", fd_pc_plus_4, 32'h0000_0000);
      chk("wr_fd_instr", fd_instruction, 32'h0000_0003);
      chk("wr_next_addr", ireq_addr, 32'h0000_0000);

      // Async reset in the middle of a wait
      ok_en = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("ar_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("ar_ireq_addr", ireq_addr, 32'hBFC0_0000);
      step();
      reset = 1'b0;
      chk("ar_rel_addr", ireq_addr, 32'hBFC0_0000);
      chk("ar_rel_valid", {31'd0, ireq_valid}, 32'd1);
      ok_en = 1'b1;
      step();
      chk("ar_first_fd_pc", fd_pc, 32'hBFC0_0000);
      chk("ar_first_fd_valid", {31'd0, fd_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
